// File: rtl/psram_emu.sv
// Cycle-sampled emulator of an ADV-latched async PSRAM: boot busy period, byte-lane writes, access-time-checked reads.
// Read data appears combinationally in the cycle OE is low; there is no backpressure, violations set a sticky err_o.
module psram_emu #(
  parameter int          ADR_W         = 10,
  parameter int          BOOT_CYCLES   = 7500,
  parameter int          ACCESS_CYCLES = 3,
  parameter logic [15:0] FILL          = 16'hDEAD
) (
  input  logic        clk2x_i,
  input  logic        reset_i,
  input  logic        ram_ce_in,
  input  logic        ram_adv_in,
  input  logic        ram_oe_in,
  input  logic        ram_we_in,
  input  logic        ram_ub_in,
  input  logic        ram_lb_in,
  input  logic [22:0] ram_adr_i,
  input  logic [15:0] ram_dq_i,
  output logic [15:0] ram_dq_o,
  output logic        ram_dq_oe_o,
  output logic        ready_o,
  output logic        err_o
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam logic [BW-1:0] BOOT_END = BOOT_CYCLES[BW-1:0];
  localparam logic [CW-1:0] ACC_END  = ACCESS_CYCLES[CW-1:0];

  typedef enum logic [1:0] {IDLE, READ, WRITE} mode_t;

  mode_t             mode;
  logic [BW-1:0]     boot_cnt;
  logic [CW-1:0]     acc_cnt;
  logic [ADR_W-1:0]  addr;
  logic [15:0]       rd_reg;
  logic [15:0]       mem [2**ADR_W];

  logic ready;
  logic acc_done;
  logic cmd;
  logic wr_en;
  logic rd_load;
  logic err_any;
  logic adr_hi_unused;

  // Address bits above ADR_W alias onto the implemented array.
  assign adr_hi_unused = ^ram_adr_i[22:ADR_W];

  assign ready    = (boot_cnt == BOOT_END);
  assign acc_done = (acc_cnt == ACC_END);
  assign cmd      = ~ram_ce_in & ~ram_adv_in & ready;
  assign wr_en    = ~ram_ce_in & ram_adv_in & (mode == WRITE);
  assign rd_load  = cmd & ram_we_in;

  assign err_any = (~ram_ce_in & ~ready)
                 | (~ram_ce_in & ~ram_oe_in & (mode != READ))
                 | (~ram_oe_in & ~ram_we_in)
                 | (~ram_ce_in & (mode == READ) & ~acc_done
                    & (~ram_oe_in | ~ram_ub_in | ~ram_lb_in));

  assign ready_o     = ready;
  assign ram_dq_oe_o = ~ram_oe_in & ~ram_ce_in & ram_we_in & (mode == READ);
  assign ram_dq_o    = acc_done ? rd_reg : FILL;

  always_ff @(posedge clk2x_i or posedge reset_i) begin
    if (reset_i) begin
      mode     <= IDLE;
      boot_cnt <= '0;
      acc_cnt  <= '0;
      addr     <= '0;
      err_o    <= 1'b0;
    end else begin
      if (!ready)
        boot_cnt <= boot_cnt + 1'b1;
      err_o <= err_o | err_any;
      if (ram_ce_in) begin
        mode <= IDLE;
      end else if (!ram_adv_in) begin
        // A command issued before boot completes is dropped entirely.
        if (ready) begin
          addr    <= ram_adr_i[ADR_W-1:0];
          acc_cnt <= '0;
          mode    <= ram_we_in ? READ : WRITE;
        end
      end else if (!acc_done) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
    end
  end

  // Array and read register carry no reset so contents survive reset_i.
  always_ff @(posedge clk2x_i) begin
    if (wr_en && !ram_lb_in)
      mem[addr][7:0] <= ram_dq_i[7:0];
    if (wr_en && !ram_ub_in)
      mem[addr][15:8] <= ram_dq_i[15:8];
    if (rd_load)
      rd_reg <= mem[ram_adr_i[ADR_W-1:0]];
  end

endmodule
